// File: rtl/seq_worker_if.sv
// Start/done handshake bundle between the stage sequencer (master) and a worker (slave).
// Carries the request operands and the worker's completion, status and result.
interface seq_worker_if #(
    parameter int WIDTH = 8
);
    logic               start;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic               done;
    logic               busy;
    logic [2*WIDTH-1:0] result;
    logic               overrun;

    modport master (
        output start, op_a, op_b,
        input  done, busy, result, overrun
    );

    modport slave (
        input  start, op_a, op_b,
        output done, busy, result, overrun
    );
endinterface

// File: rtl/seq_worker.sv
// Sequencer-side worker: on a start pulse multiplies op_a*op_b with an iterative
// shift-add loop of exactly WIDTH steps, then pulses done with the product held.
//
// state  | meaning
// IDLE   | waiting for start; result holds the last completed product
// RUN    | one shift-add iteration per clock, WIDTH iterations total
// DONE   | single-cycle done pulse, then back to IDLE unconditionally
module seq_worker #(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    seq_worker_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    count;
    logic [PW-1:0]    mcand;
    logic [PW-1:0]    acc;
    logic [PW-1:0]    acc_sum;
    logic [PW-1:0]    result_q;
    logic [WIDTH-1:0] mplier;
    logic             overrun_q;
    logic             last_iter;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        acc_sum   = mplier[0] ? (acc + mcand) : acc;
        last_iter = (count == CW'(WIDTH - 1));
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (last_iter) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath; a start outside IDLE only marks the overrun, never reloads operands.
    always_ff @(posedge clk) begin
        if (reset) begin
            count     <= '0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            result_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (bus.start && (state != S_IDLE)) begin
                overrun_q <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        mcand  <= PW'(bus.op_a);
                        mplier <= bus.op_b;
                        acc    <= '0;
                        count  <= '0;
                    end
                end
                S_RUN: begin
                    acc    <= acc_sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + CW'(1);
                    if (last_iter) begin
                        result_q <= acc_sum;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.done    = (state == S_DONE);
    assign bus.busy    = (state != S_IDLE);
    assign bus.result  = result_q;
    assign bus.overrun = overrun_q;
endmodule

// File: tb/tb_seq_worker.sv
// Self-checking bench for seq_worker: randomized and directed products on an 8-bit
// and a 16-bit instance, compared against a cycle-indexed arithmetic model.
module tb_seq_worker;
    logic clk;
    logic reset;
    int   checks;
    int   errors;
    logic [15:0] prev8;
    logic [31:0] prev16;

    seq_worker_if #(.WIDTH(8))  if8 ();
    seq_worker_if #(.WIDTH(16)) if16 ();

    seq_worker #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (if8.slave)
    );

    seq_worker #(.WIDTH(16)) dut16 (
        .clk   (clk),
        .reset (reset),
        .bus   (if16.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives a one-cycle start; returns at the falling edge just after the accepting edge.
    task automatic issue8(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        if8.start = 1'b1;
        if8.op_a  = a;
        if8.op_b  = b;
        @(negedge clk);
        if8.start = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        prev8  = '0;
        prev16 = '0;
    endtask

    task automatic test_reset();
        if8.start  = 1'b1;
        if8.op_a   = 8'd9;
        if8.op_b   = 8'd9;
        if16.start = 1'b1;
        if16.op_a  = 16'd9;
        if16.op_b  = 16'd9;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({if8.busy, if8.done, if8.overrun} !== 3'b000 || if8.result !== 16'd0) begin
            errors++;
            $display("FAIL reset8 busy/done/ovr=%b%b%b result=%0d required 000 and 0",
                     if8.busy, if8.done, if8.overrun, if8.result);
        end
        checks++;
        if ({if16.busy, if16.done, if16.overrun} !== 3'b000 || if16.result !== 32'd0) begin
            errors++;
            $display("FAIL reset16 busy/done/ovr=%b%b%b result=%0d required 000 and 0",
                     if16.busy, if16.done, if16.overrun, if16.result);
        end
        if8.start  = 1'b0;
        if16.start = 1'b0;
        reset = 1'b0;
        prev8  = '0;
        prev16 = '0;
        @(negedge clk);
    endtask

    task automatic test_products();
        logic [7:0]  ta [0:2];
        logic [7:0]  tb [0:2];
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
        logic [15:0] exp_res;
        ta[0] = 8'd13;  tb[0] = 8'd11;
        ta[1] = 8'd0;   tb[1] = 8'd200;
        ta[2] = 8'd255; tb[2] = 8'd255;
        for (int n = 0; n < 15; n++) begin
            if (n < 3) begin
                a = ta[n];
                b = tb[n];
            end else begin
                a = 8'($urandom_range(0, 255));
                b = 8'($urandom_range(0, 255));
            end
            p = 16'(a) * 16'(b);
            issue8(a, b);
            checks++;
            if (if8.busy !== 1'b1 || if8.done !== 1'b0) begin
                errors++;
                $display("FAIL accept busy=%b done=%b required 1 0 (%0d*%0d)", if8.busy, if8.done, a, b);
            end
            for (int k = 1; k <= 10; k++) begin
                @(negedge clk);
                exp_res = (k >= 8) ? p : prev8;
                checks++;
                if (if8.done !== (k == 8) || if8.busy !== (k <= 8) || if8.result !== exp_res
                    || if8.overrun !== 1'b0) begin
                    errors++;
                    $display("FAIL product %0d*%0d edge+%0d done=%b busy=%b ovr=%b result=%0d required done=%b busy=%b ovr=0 result=%0d",
                             a, b, k, if8.done, if8.busy, if8.overrun, if8.result,
                             (k == 8), (k <= 8), exp_res);
                end
            end
            prev8 = p;
        end
    endtask

    task automatic test_start_while_busy();
        logic [15:0] exp_res;
        issue8(8'd13, 8'd11);
        for (int k = 1; k <= 20; k++) begin
            if (k == 4) begin
                if8.start = 1'b1;
                if8.op_a  = 8'd2;
                if8.op_b  = 8'd2;
            end
            if (k == 5) if8.start = 1'b0;
            @(negedge clk);
            exp_res = (k >= 8) ? 16'd143 : prev8;
            checks++;
            if (if8.done !== (k == 8) || if8.busy !== (k <= 8) || if8.result !== exp_res
                || if8.overrun !== (k >= 4)) begin
                errors++;
                $display("FAIL overrun edge+%0d done=%b busy=%b ovr=%b result=%0d required done=%b busy=%b ovr=%b result=%0d",
                         k, if8.done, if8.busy, if8.overrun, if8.result,
                         (k == 8), (k <= 8), (k >= 4), exp_res);
            end
        end
        prev8 = 16'd143;
    endtask

    // start held high: accepting edges fall every WIDTH+2 edges from E.
    task automatic test_back_to_back();
        int m;
        logic [15:0] exp_res;
        @(negedge clk);
        if8.start = 1'b1;
        if8.op_a  = 8'd3;
        if8.op_b  = 8'd5;
        for (int k = 0; k <= 21; k++) begin
            @(negedge clk);
            m = k % 10;
            exp_res = (k >= 8) ? 16'd15 : prev8;
            checks++;
            if (if8.done !== (m == 8) || if8.busy !== (m != 9) || if8.result !== exp_res
                || if8.overrun !== (k >= 1)) begin
                errors++;
                $display("FAIL back_to_back edge+%0d done=%b busy=%b ovr=%b result=%0d required done=%b busy=%b ovr=%b result=%0d",
                         k, if8.done, if8.busy, if8.overrun, if8.result,
                         (m == 8), (m != 9), (k >= 1), exp_res);
            end
        end
        if8.start = 1'b0;
        repeat (12) @(negedge clk);
        prev8 = 16'd15;
    endtask

    task automatic test_reset_mid_op();
        logic exp_busy;
        logic [15:0] exp_res;
        issue8(8'd13, 8'd11);
        for (int k = 1; k <= 12; k++) begin
            if (k == 4) reset = 1'b1;
            if (k == 5) reset = 1'b0;
            @(negedge clk);
            exp_busy = (k < 4);
            exp_res  = (k < 4) ? prev8 : 16'd0;
            checks++;
            if (if8.done !== 1'b0 || if8.busy !== exp_busy || if8.result !== exp_res
                || if8.overrun !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid edge+%0d done=%b busy=%b ovr=%b result=%0d required done=0 busy=%b ovr=0 result=%0d",
                         k, if8.done, if8.busy, if8.overrun, if8.result, exp_busy, exp_res);
            end
        end
        prev8  = '0;
        prev16 = '0;
        issue8(8'd6, 8'd7);
        repeat (8) @(negedge clk);
        checks++;
        if (if8.done !== 1'b1 || if8.result !== 16'd42) begin
            errors++;
            $display("FAIL reset_recover done=%b result=%0d required 1 and 42", if8.done, if8.result);
        end
        @(negedge clk);
        prev8 = 16'd42;
    endtask

    task automatic test_wide();
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] p;
        logic [31:0] exp_res;
        for (int n = 0; n < 4; n++) begin
            a = (n == 0) ? 16'hFFFF : 16'($urandom_range(0, 65535));
            b = (n == 0) ? 16'hFFFF : 16'($urandom_range(0, 65535));
            p = 32'(a) * 32'(b);
            @(negedge clk);
            if16.start = 1'b1;
            if16.op_a  = a;
            if16.op_b  = b;
            @(negedge clk);
            if16.start = 1'b0;
            for (int k = 1; k <= 18; k++) begin
                @(negedge clk);
                exp_res = (k >= 16) ? p : prev16;
                checks++;
                if (if16.done !== (k == 16) || if16.busy !== (k <= 16) || if16.result !== exp_res) begin
                    errors++;
                    $display("FAIL wide %h*%h edge+%0d done=%b busy=%b result=%h required done=%b busy=%b result=%h",
                             a, b, k, if16.done, if16.busy, if16.result,
                             (k == 16), (k <= 16), exp_res);
                end
            end
            prev16 = p;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        prev8  = '0;
        prev16 = '0;
        reset  = 1'b0;
        if8.start  = 1'b0;
        if8.op_a   = '0;
        if8.op_b   = '0;
        if16.start = 1'b0;
        if16.op_a  = '0;
        if16.op_b  = '0;
        test_reset();
        test_products();
        test_start_while_busy();
        apply_reset();
        test_back_to_back();
        apply_reset();
        test_reset_mid_op();
        test_wide();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
